// File: rtl/clk_div_multi.sv
// clk_div_multi: NCH-channel programmable clock divider / clock-enable generator.
// Each channel has an active divisor D and a pending divisor. It produces a
// registered ~50% duty divided clock and a registered one-cycle tick per period.
// A written divisor waits for the channel's own period boundary before it is
// applied, so the outputs never show a runt pulse.
// Optional feature macro: CLKDIV_ALIGN_EN adds the align input. When align is
// high, every channel restarts at phase 0 and any pending divisor is applied.
module clk_div_multi #(
  parameter int NCH     = 4,
  parameter int CW      = 16,
  parameter int DEF_DIV = 4,
  localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en,
  input  logic [CHW-1:0] wr_ch,
  input  logic [CW-1:0]  wr_div,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] pend
`ifdef CLKDIV_ALIGN_EN
  ,
  input  logic           align
`endif
);

  localparam logic [CW-1:0] C_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_TWO  = CW'(2);
  localparam logic [CW-1:0] C_DEF  = CW'(DEF_DIV);
  localparam logic [CW:0]   C_ONE_W = (CW+1)'(1);

  // Per-channel state
  logic [CW-1:0]  r_cnt   [NCH];
  logic [CW-1:0]  r_div_q [NCH];
  logic [CW-1:0]  r_div_p [NCH];
  logic [NCH-1:0] r_pend;
  logic [NCH-1:0] r_clk_out;
  logic [NCH-1:0] r_tick;

  // Decoded per-channel conditions
  logic [CW:0]    w_half  [NCH];
  logic [NCH-1:0] w_big;
  logic [NCH-1:0] w_one;
  logic [NCH-1:0] w_last;
  logic [NCH-1:0] w_hit;
  logic [NCH-1:0] w_apply;
  logic           w_align;

  // Next-state values
  logic [CW-1:0]  w_cnt_nxt   [NCH];
  logic [CW-1:0]  w_div_q_nxt [NCH];
  logic [CW-1:0]  w_div_p_nxt [NCH];
  logic [NCH-1:0] w_pend_nxt;
  logic [NCH-1:0] w_clk_nxt;
  logic [NCH-1:0] w_tick_nxt;

`ifdef CLKDIV_ALIGN_EN
  assign w_align = align;
`else
  assign w_align = 1'b0;
`endif

  // Decode divisor class, period boundary, high-phase length and write hits.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      // Computed in CW+1 bits so the largest divisor still yields the right H.
      w_half[i]  = ({1'b0, r_div_q[i]} + C_ONE_W) >> 1'b1;
      w_big[i]   = (r_div_q[i] >= C_TWO);
      w_one[i]   = (r_div_q[i] == C_ONE);
      // A divisor below 2 has no multi-cycle period, so every edge is a boundary.
      if (w_big[i]) begin
        w_last[i] = (r_cnt[i] == (r_div_q[i] - C_ONE));
      end else begin
        w_last[i] = 1'b1;
      end
      w_hit[i]   = wr_en && (wr_ch == CHW'(i));
      w_apply[i] = r_pend[i] && w_last[i];
    end
  end

  // Next-state logic: counting, output generation, write capture and apply.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_cnt_nxt[i]   = r_cnt[i];
      w_div_q_nxt[i] = r_div_q[i];
      w_div_p_nxt[i] = r_div_p[i];
      w_pend_nxt[i]  = r_pend[i];
      w_clk_nxt[i]   = 1'b0;
      w_tick_nxt[i]  = 1'b0;

      if (w_align) begin
        // Restart at phase 0. A same-cycle write wins over the older pending value.
        w_cnt_nxt[i]  = C_ZERO;
        w_pend_nxt[i] = 1'b0;
        w_clk_nxt[i]  = 1'b0;
        w_tick_nxt[i] = 1'b0;
        if (w_hit[i]) begin
          w_div_q_nxt[i] = wr_div;
          w_div_p_nxt[i] = wr_div;
        end else if (r_pend[i]) begin
          w_div_q_nxt[i] = r_div_p[i];
        end else begin
          w_div_q_nxt[i] = r_div_q[i];
        end
      end else begin
        // The outputs on this edge always follow the divisor that is active now.
        if (w_big[i]) begin
          w_clk_nxt[i]  = ({1'b0, r_cnt[i]} < w_half[i]);
          w_tick_nxt[i] = w_last[i];
          w_cnt_nxt[i]  = w_last[i] ? C_ZERO : (r_cnt[i] + C_ONE);
        end else if (w_one[i]) begin
          w_clk_nxt[i]  = 1'b0;
          w_tick_nxt[i] = 1'b1;
          w_cnt_nxt[i]  = C_ZERO;
        end else begin
          w_clk_nxt[i]  = 1'b0;
          w_tick_nxt[i] = 1'b0;
          w_cnt_nxt[i]  = C_ZERO;
        end

        if (w_apply[i]) begin
          w_div_q_nxt[i] = r_div_p[i];
          w_cnt_nxt[i]   = C_ZERO;
        end else begin
          w_div_q_nxt[i] = r_div_q[i];
        end

        // A write on the apply edge becomes the next pending value.
        if (w_hit[i]) begin
          w_div_p_nxt[i] = wr_div;
          w_pend_nxt[i]  = 1'b1;
        end else begin
          w_div_p_nxt[i] = r_div_p[i];
          w_pend_nxt[i]  = w_apply[i] ? 1'b0 : r_pend[i];
        end
      end
    end
  end

  // Channel state registers with asynchronous reset to the default divisor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i]   <= C_ZERO;
        r_div_q[i] <= C_DEF;
        r_div_p[i] <= C_ZERO;
      end
      r_pend    <= {NCH{1'b0}};
      r_clk_out <= {NCH{1'b0}};
      r_tick    <= {NCH{1'b0}};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i]   <= w_cnt_nxt[i];
        r_div_q[i] <= w_div_q_nxt[i];
        r_div_p[i] <= w_div_p_nxt[i];
      end
      r_pend    <= w_pend_nxt;
      r_clk_out <= w_clk_nxt;
      r_tick    <= w_tick_nxt;
    end
  end

  assign clk_out = r_clk_out;
  assign tick    = r_tick;
  assign pend    = r_pend;

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: a period/phase reference model checked
// every cycle, plus directed literal sequences for reset, divisor changes,
// the disabled and divide-by-one cases, the widest divisor, async reset
// and (with CLKDIV_ALIGN_EN) alignment.
module tb_clk_div_multi;

  localparam int NCH     = 4;
  localparam int CW      = 16;
  localparam int DEF_DIV = 4;
  localparam int CHW     = 2;

  logic           clk    = 1'b0;
  logic           rst_n  = 1'b0;
  logic           wr_en  = 1'b0;
  logic [CHW-1:0] wr_ch  = '0;
  logic [CW-1:0]  wr_div = '0;
  wire  [NCH-1:0] clk_out;
  wire  [NCH-1:0] tick;
  wire  [NCH-1:0] pend;
  wire            al_w;
`ifdef CLKDIV_ALIGN_EN
  logic           align  = 1'b0;
  assign al_w = align;
`else
  assign al_w = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  clk_div_multi #(.NCH(NCH), .CW(CW), .DEF_DIV(DEF_DIV)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_div (wr_div),
    .clk_out(clk_out),
    .tick   (tick),
    .pend   (pend)
`ifdef CLKDIV_ALIGN_EN
    ,
    .align  (align)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel is a phase position inside a D-cycle period.
  int m_d   [NCH];
  int m_p   [NCH];
  int m_ph  [NCH];
  bit m_pend[NCH];
  bit m_clk [NCH];
  bit m_tick[NCH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_d[c] <= DEF_DIV; m_p[c] <= 0; m_ph[c] <= 0;
        m_pend[c] <= 1'b0; m_clk[c] <= 1'b0; m_tick[c] <= 1'b0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (al_w) begin
          m_ph[c] <= 0; m_pend[c] <= 1'b0; m_clk[c] <= 1'b0; m_tick[c] <= 1'b0;
          if (wr_en && int'(wr_ch) == c) begin
            m_d[c] <= int'(wr_div); m_p[c] <= int'(wr_div);
          end else if (m_pend[c]) begin
            m_d[c] <= m_p[c];
          end
        end else begin
          m_clk[c]  <= (m_d[c] >= 2) && (m_ph[c] < (m_d[c] + 1) / 2);
          m_tick[c] <= (m_d[c] == 1) || ((m_d[c] >= 2) && (m_ph[c] == m_d[c] - 1));
          m_ph[c]   <= (m_d[c] < 2) ? 0 : (m_ph[c] + 1) % m_d[c];
          if (m_pend[c] && (m_d[c] < 2 || m_ph[c] == m_d[c] - 1)) begin
            m_d[c] <= m_p[c]; m_ph[c] <= 0; m_pend[c] <= 1'b0;
          end
          if (wr_en && int'(wr_ch) == c) begin
            m_p[c] <= int'(wr_div); m_pend[c] <= 1'b1;
          end
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("model clk_out[%0d]", c), 32'(clk_out[c]), 32'(m_clk[c]));
        chk($sformatf("model tick[%0d]", c), 32'(tick[c]), 32'(m_tick[c]));
        chk($sformatf("model pend[%0d]", c), 32'(pend[c]), 32'(m_pend[c]));
      end
    end
  end

  task automatic wr(input int ch, input int val);
    @(negedge clk);
    wr_en = 1'b1; wr_ch = CHW'(ch); wr_div = CW'(val);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_pend_clear(input int ch, input int lim);
    int n;
    n = 0;
    while (pend[ch] && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("pend[%0d] clears within bound", ch), 32'(pend[ch]), 32'd0);
  endtask

  initial begin
    bit exp_c0 [8];
    bit exp_t0 [8];
    bit exp_c1 [5];
    bit exp_c3 [4];
    int n;
    int m;
    exp_c0 = '{1, 1, 0, 0, 1, 1, 0, 0};
    exp_t0 = '{0, 0, 0, 1, 0, 0, 0, 1};
    exp_c1 = '{1, 1, 1, 0, 0};
    exp_c3 = '{1, 1, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset clk_out", 32'(clk_out), 32'd0);
    chk("reset tick", 32'(tick), 32'd0);
    chk("reset pend", 32'(pend), 32'd0);
    #1 rst_n = 1'b1;

    // Edges counted from reset release; ch1 gets D=5 written while its cnt is 1.
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      wr_en = 1'b0;
      if (k == 10) begin
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 16'd5;
      end
      @(posedge clk);
      #1;
      if (k <= 8) begin
        chk($sformatf("default ch0 clk_out edge %0d", k), 32'(clk_out[0]), 32'(exp_c0[k-1]));
        chk($sformatf("default ch0 tick edge %0d", k), 32'(tick[0]), 32'(exp_t0[k-1]));
        chk($sformatf("default pend edge %0d", k), 32'(pend), 32'd0);
      end
      if (k >= 10 && k <= 12)
        chk($sformatf("ch1 pend edge %0d", k), 32'(pend[1]), (k == 12) ? 32'd0 : 32'd1);
      if (k >= 13 && k <= 17) begin
        chk($sformatf("ch1 D=5 clk_out edge %0d", k), 32'(clk_out[1]), 32'(exp_c1[k-13]));
        chk($sformatf("ch1 D=5 tick edge %0d", k), 32'(tick[1]), (k == 17) ? 32'd1 : 32'd0);
      end
    end
    wr_en = 1'b0;

    // ch2: disabled, then divide-by-one.
    wr(2, 0);
    wait_pend_clear(2, 20);
    repeat (6) begin
      @(negedge clk);
      chk("ch2 D=0 clk_out", 32'(clk_out[2]), 32'd0);
      chk("ch2 D=0 tick", 32'(tick[2]), 32'd0);
    end
    wr(2, 1);
    @(negedge clk);
    chk("ch2 D=1 applied next edge", 32'(pend[2]), 32'd0);
    repeat (5) begin
      @(negedge clk);
      chk("ch2 D=1 tick", 32'(tick[2]), 32'd1);
      chk("ch2 D=1 clk_out", 32'(clk_out[2]), 32'd0);
    end

    // ch0: two writes inside one period, only the last one is applied.
    n = 0;
    do begin @(negedge clk); n++; end while (!tick[0] && n < 20);
    chk("ch0 tick seen before double write", 32'(tick[0]), 32'd1);
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd6;
    @(negedge clk);
    wr_div = 16'd8;
    @(negedge clk);
    wr_en = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!tick[0] && n < 20);
    m = 0;
    do begin @(negedge clk); m++; end while (!tick[0] && m < 30);
    chk("ch0 period after double write", 32'(m), 32'd8);

    // ch3: widest divisor, high phase must still be present.
    wr(3, 65535);
    wait_pend_clear(3, 20);
    repeat (10) begin
      @(negedge clk);
      chk("ch3 D=65535 clk_out high", 32'(clk_out[3]), 32'd1);
    end
    wr(3, 4);
    chk("ch3 pend during long period", 32'(pend[3]), 32'd1);

    // Async reset mid-period with a pending write.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset clk_out", 32'(clk_out), 32'd0);
    chk("async reset tick", 32'(tick), 32'd0);
    chk("async reset pend", 32'(pend), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post-reset ch3 clk_out edge %0d", k + 1), 32'(clk_out[3]), 32'(exp_c3[k]));
      chk("post-reset pend", 32'(pend), 32'd0);
    end

`ifdef CLKDIV_ALIGN_EN
    // Put channels at different phases with D=4, then align.
    for (int c = 0; c < NCH; c++) begin
      wr(c, 4);
      repeat (c + 1) @(negedge clk);
    end
    for (int c = 0; c < NCH; c++) wait_pend_clear(c, 20);
    @(negedge clk);
    align = 1'b1;
    @(negedge clk);
    align = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("aligned clk_out uniform", 32'(clk_out == 4'h0 || clk_out == 4'hF), 32'd1);
      chk("aligned tick uniform", 32'(tick == 4'h0 || tick == 4'hF), 32'd1);
    end
`endif

    // Randomised writes (and align pulses when present) against the model.
    repeat (3000) begin
      @(negedge clk);
      wr_en  = ($urandom_range(0, 3) == 0);
      wr_ch  = CHW'($urandom_range(0, NCH - 1));
      wr_div = CW'($urandom_range(0, 9));
`ifdef CLKDIV_ALIGN_EN
      align  = ($urandom_range(0, 49) == 0);
`endif
    end
    @(negedge clk);
    wr_en = 1'b0;
`ifdef CLKDIV_ALIGN_EN
    align = 1'b0;
`endif
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
